cc_obstacle_generator: RTL



---
 rtl/cc_roadfighter_pkg.sv | 44 ++++
 rtl/cc_obstacle_generator_if.sv | 30 +++
 rtl/cc_lfsr16.sv | 29 ++
 rtl/cc_obstacle_generator.sv | 112 +++++++++++
 4 files changed

// File: rtl/cc_roadfighter_pkg.sv
// Shared types and constants for the road-fighter obstacle path.
// Also used by the gameplay stage for the blocking patterns.
package cc_roadfighter_pkg;

  // STROBE owns bit 2 alone so the load strobe is a single flop
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_RUN    = 3'b001,
    S_GEN    = 3'b011,
    S_STROBE = 3'b100
  } obs_state_t;

  localparam int LANES   = 4;
  localparam int P0_BASE = 0;
  localparam int P1_BASE = 4;
  localparam int RDW     = 8;

  localparam logic [7:0] BLOCK_P0 = 8'h0F;
  localparam logic [7:0] BLOCK_P1 = 8'hF0;

  localparam logic [15:0] SEED_DEF  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MIN_PERIOD = 4;

  function automatic logic [7:0] lane_bit(
    input logic [1:0] lane,
    input int         base
  );
    lane_bit = 8'h01 << (base + int'(lane));
  endfunction

  // {p1, p0}; one-hot lanes can never form a blocking pattern
  function automatic logic [15:0] build_row(
    input logic [15:0] l
  );
    logic [7:0] p0;
    logic [7:0] p1;
    p0 = l[5] ? lane_bit(l[1:0], P0_BASE) : 8'h00;
    p1 = l[6] ? lane_bit(l[4:3], P1_BASE) : 8'h00;
    build_row = {p1, p0};
  endfunction

endpackage

// File: rtl/cc_obstacle_generator_if.sv
// Row bus between the obstacle generator and the gameplay stage.
interface cc_obstacle_generator_if;
  import cc_roadfighter_pkg::*;

  logic           CC_ObstacleGen_enable_InHigh;
  logic [1:0]     CC_ObstacleGen_speed_InBUS;
  logic [RDW-1:0] P0_CC_ObstacleGen_data_OutBUS;
  logic [RDW-1:0] P1_CC_ObstacleGen_data_OutBUS;
  logic           CC_ObstacleGen_load_OutLow;
  logic [7:0]     CC_ObstacleGen_rowCount_OutBUS;

  modport master (
    input  CC_ObstacleGen_enable_InHigh,
    input  CC_ObstacleGen_speed_InBUS,
    output P0_CC_ObstacleGen_data_OutBUS,
    output P1_CC_ObstacleGen_data_OutBUS,
    output CC_ObstacleGen_load_OutLow,
    output CC_ObstacleGen_rowCount_OutBUS
  );

  modport slave (
    output CC_ObstacleGen_enable_InHigh,
    output CC_ObstacleGen_speed_InBUS,
    input  P0_CC_ObstacleGen_data_OutBUS,
    input  P1_CC_ObstacleGen_data_OutBUS,
    input  CC_ObstacleGen_load_OutLow,
    input  CC_ObstacleGen_rowCount_OutBUS
  );

endinterface

// File: rtl/cc_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, self-recovering from zero.
module cc_lfsr16
  import cc_roadfighter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] nxt;

  always_comb begin
    nxt = {1'b0, state[15:1]};
    if (state[0]) nxt = nxt ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= seed;
    end else if (state == 16'h0000) begin
      state <= seed;
    end else if (en) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/cc_obstacle_generator.sv
// Paces the road scroll and emits one LFSR-built obstacle row per tick.
module cc_obstacle_generator
  import cc_roadfighter_pkg::*;
#(
  parameter int          TICK_PERIOD = 25000000,
  parameter int          GAP_ROWS    = 2,
  parameter logic [15:0] LFSR_SEED   = SEED_DEF,
  parameter int          RDATAWIDTH  = RDW
) (
  input logic CC_ObstacleGen_CLOCK_50,
  input logic CC_ObstacleGen_RESET_InLow,
  cc_obstacle_generator_if.master bus
);

  localparam int CB = $clog2(TICK_PERIOD + 1);
  localparam int CW = (CB < 3) ? 3 : CB;

  logic clk;
  logic rst_n;
  logic en;
  assign clk   = CC_ObstacleGen_CLOCK_50;
  assign rst_n = CC_ObstacleGen_RESET_InLow;
  assign en    = bus.CC_ObstacleGen_enable_InHigh;

  obs_state_t state;
  obs_state_t nxt_state;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         per;
  logic                  tick;
  logic [3:0]            gap;
  logic [15:0]           lfsr;
  logic [15:0]           row;
  logic [RDATAWIDTH-1:0] p0_q;
  logic [RDATAWIDTH-1:0] p1_q;
  logic [7:0]            rc;

  cc_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  // faster speeds shorten the period but never below the floor
  always_comb begin
    per = CW'(TICK_PERIOD >> bus.CC_ObstacleGen_speed_InBUS);
    if (per < CW'(MIN_PERIOD)) per = CW'(MIN_PERIOD);
  end

  assign tick = (cnt >= per - CW'(1));
  assign row  = build_row(lfsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      S_IDLE: begin
        if (en) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (!en)       nxt_state = S_IDLE;
        else if (tick) nxt_state = S_GEN;
      end
      S_GEN: begin
        nxt_state = S_STROBE;
      end
      S_STROBE: begin
        nxt_state = en ? S_RUN : S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      gap  <= '0;
      p0_q <= '0;
      p1_q <= '0;
      rc   <= '0;
    end else begin
      if (state == S_IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
      if (state == S_GEN) begin
        if (gap != 4'd0) begin
          p0_q <= '0;
          p1_q <= '0;
          gap  <= gap - 4'd1;
        end else begin
          p0_q <= RDATAWIDTH'(row[7:0]);
          p1_q <= RDATAWIDTH'(row[15:8]);
          gap  <= 4'(GAP_ROWS);
        end
      end
      if (state == S_STROBE) rc <= rc + 8'd1;
    end
  end

  assign bus.P0_CC_ObstacleGen_data_OutBUS  = RDW'(p0_q);
  assign bus.P1_CC_ObstacleGen_data_OutBUS  = RDW'(p1_q);
  assign bus.CC_ObstacleGen_load_OutLow     = ~state[2];
  assign bus.CC_ObstacleGen_rowCount_OutBUS = rc;

endmodule
